// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the elastic pipeline-stage registers: state encoding
// and per-stage bundle widths with the field offsets the stage wrappers use.
package pipe_skid_reg_pkg;

  typedef enum logic [1:0] {
    PSR_EMPTY = 2'd0,
    PSR_BUSY  = 2'd1,
    PSR_FULL  = 2'd2
  } psr_state_e;

  // ID/EX bundle: ctrl = {S, B, MEM_R_EN, MEM_W_EN, WB_EN, EXE_CMD[3:0], spare}
  localparam int ID_EX_CTRL_W      = 16;
  localparam int ID_EX_DATA_W      = 128;
  localparam int ID_EX_CTRL_S      = 0;
  localparam int ID_EX_CTRL_B      = 1;
  localparam int ID_EX_CTRL_MEM_R  = 2;
  localparam int ID_EX_CTRL_MEM_W  = 3;
  localparam int ID_EX_CTRL_WB_EN  = 4;
  localparam int ID_EX_CTRL_EXE    = 5;
  localparam int ID_EX_DATA_RN     = 0;
  localparam int ID_EX_DATA_RM     = 32;
  localparam int ID_EX_DATA_PC     = 64;
  localparam int ID_EX_DATA_IMM    = 96;

  // EX/MEM bundle
  localparam int EX_MEM_CTRL_W     = 8;
  localparam int EX_MEM_DATA_W     = 72;
  localparam int EX_MEM_CTRL_MEM_R = 0;
  localparam int EX_MEM_CTRL_MEM_W = 1;
  localparam int EX_MEM_CTRL_WB_EN = 2;
  localparam int EX_MEM_DATA_ALU   = 0;
  localparam int EX_MEM_DATA_RM    = 32;
  localparam int EX_MEM_DATA_DEST  = 64;

  // MEM/WB bundle
  localparam int MEM_WB_CTRL_W     = 4;
  localparam int MEM_WB_DATA_W     = 72;
  localparam int MEM_WB_CTRL_MEM_R = 0;
  localparam int MEM_WB_CTRL_WB_EN = 1;
  localparam int MEM_WB_DATA_ALU   = 0;
  localparam int MEM_WB_DATA_MEM   = 32;
  localparam int MEM_WB_DATA_DEST  = 64;

endpackage

// File: rtl/pipe_skid_reg_entry.sv
// One ctrl+data storage slot: load has priority over clear; data clearing on
// clear is optional so wide data paths can skip the extra enable fan-out.
module pipe_entry_reg #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic              clr_data,
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic [DATA_W-1:0] ld_data,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // Reset zeroes data as well, so a freshly reset stage never shows stale data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl <= '0;
      data <= '0;
    end else if (load) begin
      ctrl <= ld_ctrl;
      data <= ld_data;
    end else if (clr) begin
      ctrl <= '0;
      if (clr_data) data <= '0;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline-stage register with a 2-entry skid buffer, valid/ready
// handshake and synchronous flush; in_ready comes straight from state flops.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int CTRL_W     = 16,
  parameter int DATA_W     = 128,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  psr_state_e        state;
  logic              in_fire;
  logic              out_fire;
  logic              main_ld;
  logic              main_clr;
  logic              skid_ld;
  logic              skid_clr;
  logic [CTRL_W-1:0] main_ld_ctrl;
  logic [DATA_W-1:0] main_ld_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  assign in_ready  = (state != PSR_FULL);
  assign out_valid = (state != PSR_EMPTY);
  assign occupancy = state;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    main_ld      = 1'b0;
    main_clr     = 1'b0;
    skid_ld      = 1'b0;
    skid_clr     = 1'b0;
    main_ld_ctrl = in_ctrl;
    main_ld_data = in_data;
    if (flush) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state)
        PSR_EMPTY: main_ld = in_fire;
        PSR_BUSY: begin
          if (in_fire && out_fire) main_ld = 1'b1;
          else if (in_fire)        skid_ld = 1'b1;
          else if (out_fire)       main_clr = 1'b1;
        end
        PSR_FULL: begin
          if (out_fire) begin
            main_ld      = 1'b1;
            main_ld_ctrl = skid_ctrl;
            main_ld_data = skid_data;
            skid_clr     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= PSR_EMPTY;
    end else if (flush) begin
      state <= PSR_EMPTY;
    end else begin
      case (state)
        PSR_EMPTY: if (in_fire) state <= PSR_BUSY;
        PSR_BUSY: begin
          if (in_fire && !out_fire)      state <= PSR_FULL;
          else if (!in_fire && out_fire) state <= PSR_EMPTY;
        end
        PSR_FULL:  if (out_fire) state <= PSR_BUSY;
        default:   state <= PSR_EMPTY;
      endcase
    end
  end

  pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk      (clk),
    .rst      (rst),
    .load     (main_ld),
    .clr      (main_clr),
    .clr_data (CLEAR_DATA),
    .ld_ctrl  (main_ld_ctrl),
    .ld_data  (main_ld_data),
    .ctrl     (out_ctrl),
    .data     (out_data)
  );

  pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_ld),
    .clr      (skid_clr),
    .clr_data (CLEAR_DATA),
    .ld_ctrl  (in_ctrl),
    .ld_data  (in_data),
    .ctrl     (skid_ctrl),
    .data     (skid_data)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vector table, hand-written flush/drain
// sequences on both CLEAR_DATA variants, then random traffic against a queue model.
module tb_pipe_skid_reg;

  localparam int CW = 16;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;

  logic          ir0, ov0, ir1, ov1;
  logic [CW-1:0] oc0, oc1;
  logic [DW-1:0] od0, od1;
  logic [1:0]    occ0, occ1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b1)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov0), .out_ready(out_ready),
    .out_ctrl(oc0), .out_data(od0), .occupancy(occ0)
  );

  pipe_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b0)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov1), .out_ready(out_ready),
    .out_ctrl(oc1), .out_data(od1), .occupancy(occ1)
  );

  typedef struct {
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic          out_ready;
    logic          e_ov;
    logic          e_ir;
    logic [1:0]    e_occ;
    logic [CW-1:0] e_ctrl;
  } vec_t;

  typedef struct {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } entry_t;

  vec_t   tbl[$];
  entry_t model_q[$];

  function automatic logic [DW-1:0] mkdata(input logic [CW-1:0] c);
    return {8{c}};
  endfunction

  function automatic vec_t mk(input logic r, input logic f, input logic iv,
                              input logic [CW-1:0] ic, input logic ordy,
                              input logic eov, input logic eir,
                              input logic [1:0] eocc, input logic [CW-1:0] ectrl);
    vec_t v;
    v.rst = r; v.flush = f; v.in_valid = iv; v.in_ctrl = ic; v.out_ready = ordy;
    v.e_ov = eov; v.e_ir = eir; v.e_occ = eocc; v.e_ctrl = ectrl;
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [CW-1:0] ic, input logic ordy);
    rst = r; flush = f; in_valid = iv; in_ctrl = ic; in_data = mkdata(ic); out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst flush iv ctrl ordy | ov ir occ ctrl
    tbl.push_back(mk(0, 0, 1, 16'hFFFF, 0, 0, 1, 0, 16'h0));
    tbl.push_back(mk(0, 0, 1, 16'hFFFF, 0, 0, 1, 0, 16'h0));
    tbl.push_back(mk(1, 0, 1, 16'h0001, 1, 1, 1, 1, 16'h1));
    tbl.push_back(mk(1, 0, 1, 16'h0002, 1, 1, 1, 1, 16'h2));
    tbl.push_back(mk(1, 0, 1, 16'h0003, 1, 1, 1, 1, 16'h3));
    tbl.push_back(mk(1, 0, 1, 16'h0004, 1, 1, 1, 1, 16'h4));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 1, 0, 16'h0));
    tbl.push_back(mk(1, 0, 1, 16'h000A, 0, 1, 1, 1, 16'hA));
    tbl.push_back(mk(1, 0, 1, 16'h000B, 0, 1, 0, 2, 16'hA));
    tbl.push_back(mk(1, 0, 1, 16'h000C, 0, 1, 0, 2, 16'hA));
    tbl.push_back(mk(1, 0, 1, 16'h000C, 1, 1, 1, 1, 16'hB));
    tbl.push_back(mk(1, 0, 1, 16'h000C, 1, 1, 1, 1, 16'hC));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 1, 0, 16'h0));
    tbl.push_back(mk(1, 0, 1, 16'h0021, 0, 1, 1, 1, 16'h21));
    tbl.push_back(mk(1, 0, 1, 16'h0022, 0, 1, 0, 2, 16'h21));
    tbl.push_back(mk(1, 1, 1, 16'h00DD, 0, 0, 1, 0, 16'h0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 1, 0, 16'h0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 1, 0, 16'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].flush, tbl[i].in_valid, tbl[i].in_ctrl, tbl[i].out_ready);
      check($sformatf("vec%0d out_valid", i), DW'(ov0), DW'(tbl[i].e_ov));
      check($sformatf("vec%0d in_ready", i), DW'(ir0), DW'(tbl[i].e_ir));
      check($sformatf("vec%0d occupancy", i), DW'(occ0), DW'(tbl[i].e_occ));
      check($sformatf("vec%0d out_ctrl", i), DW'(oc0), DW'(tbl[i].e_ctrl));
      check($sformatf("vec%0d out_data", i), od0, tbl[i].e_ov ? mkdata(tbl[i].e_ctrl) : '0);
      check($sformatf("vec%0d out_ctrl keep", i), DW'(oc1), DW'(tbl[i].e_ctrl));
    end

    // Flush coinciding with out_fire while BUSY
    drive(1, 0, 1, 16'h005E, 0);
    check("flushfire pre occ", DW'(occ1), DW'(2'd1));
    drive(1, 1, 0, 16'h0000, 1);
    check("flushfire occ", DW'(occ0), DW'(2'd0));
    check("flushfire out_valid", DW'(ov0), DW'(1'b0));
    check("flushfire out_ctrl", DW'(oc0), '0);
    check("flushfire out_data clear", od0, '0);
    check("flushfire out_ctrl keep", DW'(oc1), '0);
    check("flushfire out_data keep", od1, mkdata(16'h005E));

    // Plain drain: data retained only without CLEAR_DATA
    drive(1, 0, 1, 16'h0077, 0);
    drive(1, 0, 0, 16'h0000, 1);
    check("drain out_valid", DW'(ov1), DW'(1'b0));
    check("drain out_ctrl keep", DW'(oc1), '0);
    check("drain out_data keep", od1, mkdata(16'h0077));
    check("drain out_data clear", od0, '0);

    // Reset clears data regardless of CLEAR_DATA
    drive(0, 0, 0, 16'h0000, 0);
    check("reset out_data keep", od1, '0);
    check("reset in_ready", DW'(ir1), DW'(1'b1));

    // Random traffic against a queue model of held entries
    rst = 1'b1;
    model_q.delete();
    for (int c = 0; c < 10000; c++) begin
      logic   fl, iv, ordy, ifire, ofire;
      entry_t e;
      fl   = ($urandom_range(0, 99) < 2);
      iv   = ($urandom_range(0, 2) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      e.ctrl = CW'($urandom);
      e.data = {$urandom, $urandom, $urandom, $urandom};
      flush = fl; in_valid = iv; in_ctrl = e.ctrl; in_data = e.data; out_ready = ordy;
      if (fl) begin
        model_q.delete();
      end else begin
        ifire = iv && (model_q.size() < 2);
        ofire = ordy && (model_q.size() > 0);
        if (ofire) void'(model_q.pop_front());
        if (ifire) model_q.push_back(e);
      end
      @(posedge clk);
      #1;
      check($sformatf("rnd%0d occupancy", c), DW'(occ0), DW'(model_q.size()));
      check($sformatf("rnd%0d out_valid", c), DW'(ov0), DW'(model_q.size() > 0));
      check($sformatf("rnd%0d in_ready", c), DW'(ir0), DW'(model_q.size() < 2));
      if (model_q.size() > 0) begin
        check($sformatf("rnd%0d out_ctrl", c), DW'(oc0), DW'(model_q[0].ctrl));
        check($sformatf("rnd%0d out_data", c), od0, model_q[0].data);
        check($sformatf("rnd%0d out_data keep", c), od1, model_q[0].data);
      end else begin
        check($sformatf("rnd%0d idle out_ctrl", c), DW'(oc0), '0);
        check($sformatf("rnd%0d idle out_ctrl keep", c), DW'(oc1), '0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
